// File: rtl/pitch_shift_frame_if.sv
// Sample-stream bundle between the codec side and the pitch shifter.
//   sample_in/ready/mode/step_in : driven by the master (codec side)
//   sample_out/sample_count/frame_start/busy/overrun : driven by the shifter (slave)
interface pitch_shift_frame_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int FRAC_W = 8
);
   logic signed [DATA_W-1:0] sample_in;
   logic                     ready;
   logic [1:0]               mode;
   logic [FRAC_W+1:0]        step_in;
   logic signed [DATA_W-1:0] sample_out;
   logic [ADDR_W-1:0]        sample_count;
   logic                     frame_start;
   logic                     busy;
   logic                     overrun;

   modport master (
      output sample_in, ready, mode, step_in,
      input  sample_out, sample_count, frame_start, busy, overrun
   );

   modport slave (
      input  sample_in, ready, mode, step_in,
      output sample_out, sample_count, frame_start, busy, overrun
   );
endinterface

// File: rtl/pitch_shift_frame.sv
// Frame-based pitch shifter.
// Collects 2^ADDR_W samples into a ping-pong input buffer, resamples each full
// frame by a fractional step with wrap-around linear interpolation, and plays
// the result from a ping-pong output buffer, one sample per ready strobe.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : slave side of pitch_shift_frame_if (sample stream, mode/step,
//           sample_count, frame_start, busy, sticky overrun)
module pitch_shift_frame #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int FRAC_W    = 8,
   parameter int RISE_STEP = 320,
   parameter int FALL_STEP = 192
) (
   input  logic          clk,
   input  logic          reset,
   pitch_shift_frame_if.slave bus
);
   localparam int FRAME_LEN = 1 << ADDR_W;
   localparam int PW        = ADDR_W + FRAC_W;
   localparam int SW        = FRAC_W + 2;
   localparam int PRW       = DATA_W + FRAC_W + 2;
   localparam logic [SW-1:0] STEP_ONE = SW'(1 << FRAC_W);

   typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, WR, DONE} state_t;

   logic signed [DATA_W-1:0] in_bank  [0:1][0:FRAME_LEN-1];
   logic signed [DATA_W-1:0] out_bank [0:1][0:FRAME_LEN-1];

   state_t                   state, state_next;
   logic                     wsel, psel, rsel, proc_valid;
   logic [ADDR_W-1:0]        count, k;
   logic [PW-1:0]            pos;
   logic [SW-1:0]            step, step_sel;
   logic signed [DATA_W-1:0] a, b, y, interp, smp_out;
   logic signed [PRW-1:0]    diff, prod;
   logic [ADDR_W-1:0]        idx, idx_next;
   logic [FRAC_W-1:0]        frac;
   logic                     fstart, ovr, wrap, start, busy, done;

   assign wrap     = bus.ready && (&count);
   assign start    = wrap && !busy;
   assign idx      = pos[PW-1:FRAC_W];
   assign frac     = pos[FRAC_W-1:0];
   assign idx_next = idx + ADDR_W'(1);

   assign bus.sample_out   = smp_out;
   assign bus.sample_count = count;
   assign bus.frame_start  = fstart;
   assign bus.busy         = busy;
   assign bus.overrun      = ovr;

   // step selection, only latched when the engine starts
   always_comb begin
      step_sel = STEP_ONE;
      unique case (bus.mode)
         2'b00: step_sel = STEP_ONE;
         2'b01: step_sel = SW'(RISE_STEP);
         2'b10: step_sel = SW'(FALL_STEP);
         2'b11: step_sel = (bus.step_in == '0) ? STEP_ONE : bus.step_in;
      endcase
   end

   // y = a + ((b - a) * f) >>> FRAC_W; the result lies between a and b,
   // so the final truncation to DATA_W bits is exact
   always_comb begin
      diff   = PRW'(b) - PRW'(a);
      prod   = diff * PRW'($signed({1'b0, frac}));
      interp = DATA_W'(PRW'(a) + (prod >>> FRAC_W));
   end

   // engine FSM: next state and status
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: if (start) state_next = RD0;
         RD0: begin state_next = RD1;  busy = 1'b1; end
         RD1: begin state_next = CALC; busy = 1'b1; end
         CALC: begin state_next = WR;  busy = 1'b1; end
         WR: begin
            state_next = (&k) ? DONE : RD0;
            busy       = 1'b1;
         end
         DONE: begin
            state_next = start ? RD0 : IDLE;
            done       = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // engine datapath
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         rsel  <= 1'b0;
         step  <= '0;
         pos   <= '0;
         k     <= '0;
         a     <= '0;
         b     <= '0;
         y     <= '0;
      end else begin
         state <= state_next;
         if (start) begin
            rsel <= wsel;
            step <= step_sel;
            pos  <= '0;
            k    <= '0;
         end
         case (state)
            RD0:  a <= in_bank[rsel][idx];
            RD1:  b <= in_bank[rsel][idx_next];
            CALC: y <= interp;
            WR: begin
               pos <= pos + PW'(step);
               k   <= k + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   // input/output sample side
   always_ff @(posedge clk) begin
      if (!reset) begin
         smp_out    <= '0;
         count      <= '0;
         fstart     <= 1'b0;
         ovr        <= 1'b0;
         wsel       <= 1'b0;
         psel       <= 1'b0;
         proc_valid <= 1'b0;
      end else begin
         fstart <= wrap;
         if (bus.ready) begin
            smp_out <= out_bank[psel][count];
            count   <= count + ADDR_W'(1);
         end
         // a frame finishing in the same cycle as the wrap is consumed at
         // once, so a restarting engine never writes the bank it just filled
         if (wrap) begin
            wsel <= ~wsel;
            if (busy) ovr <= 1'b1;
            if (proc_valid || done) begin
               psel       <= ~psel;
               proc_valid <= 1'b0;
            end
         end else if (done) begin
            proc_valid <= 1'b1;
         end
      end
   end

   // buffers are intentionally not reset
   always_ff @(posedge clk) begin
      if (reset && bus.ready) in_bank[wsel][count] <= bus.sample_in;
   end

   always_ff @(posedge clk) begin
      if (reset && state == WR) out_bank[~psel][k] <= y;
   end
endmodule
